// File: rtl/xgriscv_regfile_mp_if.sv
// Issue/writeback-side bundle for the multi-port register file: read ports, write ports,
// scoreboard set and the full pending vector.
interface xgriscv_regfile_mp_if #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
);
  logic [NREAD*AW-1:0]    ra;
  logic [NREAD*XLEN-1:0]  rd;
  logic [NREAD-1:0]       rpend;
  logic [NWRITE-1:0]      we;
  logic [NWRITE*AW-1:0]   wa;
  logic [NWRITE*XLEN-1:0] wd;
  logic                   iss_v;
  logic [AW-1:0]          iss_rd;
  logic [NREG-1:0]        pend_vec;

  modport master (
    output ra, we, wa, wd, iss_v, iss_rd,
    input  rd, rpend, pend_vec
  );

  modport slave (
    input  ra, we, wa, wd, iss_v, iss_rd,
    output rd, rpend, pend_vec
  );
endinterface

// File: rtl/xgriscv_regfile_mp.sv
// Multi-port GPR file with same-cycle write-to-read bypass and a per-register
// pending-write scoreboard for RAW hazard detection at issue.
module xgriscv_regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  xgriscv_regfile_mp_if.slave  rf_if
);

  logic [XLEN-1:0]       rf_q [NREG];
  logic [NREG-1:0]       pend_q;
  logic [NREG-1:0]       pend_d;
  logic [NREAD*XLEN-1:0] rd_c;
  logic [NREAD-1:0]      rpend_c;

  // A dropped write targets the hardwired zero register.
  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Clears from writeback first, then issue sets, so a re-issued producer keeps its bit.
  always_comb begin
    pend_d = pend_q;
    for (int j = 0; j < NWRITE; j++) begin
      if (rf_if.we[j]) pend_d[rf_if.wa[j*AW +: AW]] = 1'b0;
    end
    if (rf_if.iss_v) pend_d[rf_if.iss_rd] = 1'b1;
    if (ZERO_REG) pend_d[0] = 1'b0;
  end

  // NOTE: the array is a flop array that must read 0 after reset, so every entry
  // sits in the async reset branch rather than being left uninitialised like a RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) rf_q[r] <= '0;
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
      // NOTE: non-blocking updates in port order; the last one scheduled (highest
      // port index) wins a write-write collision on the same register.
      for (int j = 0; j < NWRITE; j++) begin
        if (rf_if.we[j] && !is_zero_reg(rf_if.wa[j*AW +: AW]))
          rf_q[rf_if.wa[j*AW +: AW]] <= rf_if.wd[j*XLEN +: XLEN];
      end
    end
  end

  // Read ports never see iss_v/iss_rd, only stored state plus in-flight writes.
  logic [AW-1:0]   ra_cur;
  logic [XLEN-1:0] data_cur;
  logic            hit_cur;

  always_comb begin
    rd_c     = '0;
    rpend_c  = '0;
    ra_cur   = '0;
    data_cur = '0;
    hit_cur  = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      ra_cur   = rf_if.ra[i*AW +: AW];
      data_cur = rf_q[ra_cur];
      hit_cur  = 1'b0;
      for (int j = 0; j < NWRITE; j++) begin
        if (rf_if.we[j] && (rf_if.wa[j*AW +: AW] == ra_cur)) begin
          data_cur = rf_if.wd[j*XLEN +: XLEN];
          hit_cur  = 1'b1;
        end
      end
      if (is_zero_reg(ra_cur)) data_cur = '0;
      if (!reset) begin
        rd_c[i*XLEN +: XLEN] = data_cur;
        rpend_c[i]           = pend_q[ra_cur] & ~hit_cur;
      end
    end
  end

  assign rf_if.rd       = rd_c;
  assign rf_if.rpend    = rpend_c;
  assign rf_if.pend_vec = pend_q;

endmodule

// File: tb/tb_xgriscv_regfile_mp.sv
// Bench for xgriscv_regfile_mp: default config (directed + random) and a 4R/1W/64-bit
// config without a zero register (random), both against array-based models.
module tb_xgriscv_regfile_mp;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic chk_en = 1'b0;
  logic done_b = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  xgriscv_regfile_mp_if #(.XLEN(32), .NREG(32), .AW(5), .NREAD(2), .NWRITE(2)) bus_a ();
  xgriscv_regfile_mp_if #(.XLEN(64), .NREG(32), .AW(5), .NREAD(4), .NWRITE(1)) bus_b ();

  xgriscv_regfile_mp #(.XLEN(32), .NREG(32), .AW(5), .NREAD(2), .NWRITE(2), .ZERO_REG(1'b1))
    dut_a (.clk(clk), .reset(reset), .rf_if(bus_a));

  xgriscv_regfile_mp #(.XLEN(64), .NREG(32), .AW(5), .NREAD(4), .NWRITE(1), .ZERO_REG(1'b0))
    dut_b (.clk(clk), .reset(reset), .rf_if(bus_b));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference models ----------------
  logic [31:0] mem_a [32];
  logic [31:0] pend_a;
  logic [63:0] mem_b [32];
  logic [31:0] pend_b;

  // Scoreboard rule: drop every register written this cycle, add the issued one.
  function automatic logic [31:0] next_pend(input logic [31:0] p, input logic [1:0] we,
                                            input logic [9:0] wa, input logic iv,
                                            input logic [4:0] ird, input logic zr);
    logic [31:0] clr;
    logic [31:0] set;
    logic [31:0] nxt;
    clr = (we[0] ? (32'd1 << wa[4:0]) : 32'd0) | (we[1] ? (32'd1 << wa[9:5]) : 32'd0);
    set = iv ? (32'd1 << ird) : 32'd0;
    nxt = (p & ~clr) | set;
    if (zr) nxt[0] = 1'b0;
    return nxt;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        mem_a[r] <= '0;
        mem_b[r] <= '0;
      end
      pend_a <= '0;
      pend_b <= '0;
    end else begin
      for (int j = 0; j < 2; j++)
        if (bus_a.we[j] && bus_a.wa[j*5 +: 5] != 5'd0)
          mem_a[bus_a.wa[j*5 +: 5]] <= bus_a.wd[j*32 +: 32];
      if (bus_b.we[0]) mem_b[bus_b.wa] <= bus_b.wd;
      pend_a <= next_pend(pend_a, bus_a.we, bus_a.wa, bus_a.iss_v, bus_a.iss_rd, 1'b1);
      pend_b <= next_pend(pend_b, {1'b0, bus_b.we}, {5'd0, bus_b.wa}, bus_b.iss_v,
                          bus_b.iss_rd, 1'b0);
    end
  end

  // Expected read of config A: x0 is zero, else the last enabled writer to that
  // register this cycle, else the stored value.
  function automatic logic [31:0] exp_rd_a(input int i);
    logic [4:0]  a;
    logic [31:0] v;
    a = bus_a.ra[i*5 +: 5];
    if (reset || a == 5'd0) return 32'd0;
    v = mem_a[a];
    if (bus_a.we[0] && bus_a.wa[4:0] == a) v = bus_a.wd[31:0];
    if (bus_a.we[1] && bus_a.wa[9:5] == a) v = bus_a.wd[63:32];
    return v;
  endfunction

  function automatic logic exp_rpend_a(input int i);
    logic [4:0] a;
    logic       inflight;
    a = bus_a.ra[i*5 +: 5];
    inflight = (bus_a.we[0] && bus_a.wa[4:0] == a) || (bus_a.we[1] && bus_a.wa[9:5] == a);
    return !reset && pend_a[a] && !inflight;
  endfunction

  function automatic logic [63:0] exp_rd_b(input int i);
    logic [4:0] a;
    a = bus_b.ra[i*5 +: 5];
    if (reset) return 64'd0;
    return (bus_b.we[0] && bus_b.wa == a) ? bus_b.wd : mem_b[a];
  endfunction

  function automatic logic exp_rpend_b(input int i);
    logic [4:0] a;
    a = bus_b.ra[i*5 +: 5];
    return !reset && pend_b[a] && !(bus_b.we[0] && bus_b.wa == a);
  endfunction

  // Cycle-by-cycle comparison at the falling edge, mid-way between input changes.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0] ea;
      logic [3:0] eb;
      for (int i = 0; i < 2; i++) begin
        check($sformatf("a_rd%0d", i), 64'(bus_a.rd[i*32 +: 32]), 64'(exp_rd_a(i)));
        ea[i] = exp_rpend_a(i);
      end
      check("a_rpend", 64'(bus_a.rpend), 64'(ea));
      check("a_pend_vec", 64'(bus_a.pend_vec), 64'(pend_a));
      for (int i = 0; i < 4; i++) begin
        check($sformatf("b_rd%0d", i), bus_b.rd[i*64 +: 64], exp_rd_b(i));
        eb[i] = exp_rpend_b(i);
      end
      check("b_rpend", 64'(bus_b.rpend), 64'(eb));
      check("b_pend_vec", 64'(bus_b.pend_vec), 64'(pend_b));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.we    = '0;
    bus_a.iss_v = 1'b0;
  endtask

  task automatic wr_a(input int j, input logic [4:0] a, input logic [31:0] d);
    bus_a.we[j]          = 1'b1;
    bus_a.wa[j*5 +: 5]   = a;
    bus_a.wd[j*32 +: 32] = d;
  endtask

  task automatic iss_a(input logic [4:0] a);
    bus_a.iss_v  = 1'b1;
    bus_a.iss_rd = a;
  endtask

  function automatic logic [4:0] rand_addr();
    return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  // ---------------- config B random driver ----------------
  initial begin
    bus_b.ra = '0; bus_b.we = '0; bus_b.wa = '0; bus_b.wd = '0;
    bus_b.iss_v = 1'b0; bus_b.iss_rd = '0;
    wait (chk_en && !reset);
    for (int c = 0; c < 10000; c++) begin
      step();
      bus_b.we     = 1'($urandom_range(0, 1));
      bus_b.wa     = rand_addr();
      bus_b.wd     = {$urandom(), $urandom()};
      bus_b.iss_v  = 1'($urandom_range(0, 1));
      bus_b.iss_rd = ($urandom_range(0, 3) == 0) ? bus_b.wa : rand_addr();
      for (int i = 0; i < 4; i++)
        bus_b.ra[i*5 +: 5] = ($urandom_range(0, 3) == 0) ? bus_b.wa : rand_addr();
    end
    step();
    bus_b.we    = '0;
    bus_b.iss_v = 1'b0;
    done_b      = 1'b1;
  end

  // ---------------- config A directed + random, then summary ----------------
  initial begin
    bus_a.ra = '0; bus_a.we = '0; bus_a.wa = '0; bus_a.wd = '0;
    bus_a.iss_v = 1'b0; bus_a.iss_rd = '0;
    #2 reset = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    step();
    check("rst_pend_vec", 64'(bus_a.pend_vec), 64'd0);

    // x5 written, a different register pending, then an async reset mid-cycle
    bus_a.ra[4:0] = 5'd5;
    wr_a(0, 5'd5, 32'hDEADBEEF);
    iss_a(5'd12);
    step();
    idle_a();
    #1;
    check("x5_written", 64'(bus_a.rd[31:0]), 64'hDEADBEEF);
    check("pend12_set", 64'(bus_a.pend_vec), 64'h0000_1000);
    wr_a(0, 5'd5, 32'hCAFEF00D);
    #1 reset = 1'b1;
    #1;
    check("rst_rd_no_bypass", 64'(bus_a.rd[31:0]), 64'd0);
    check("rst_pend_cleared", 64'(bus_a.pend_vec), 64'd0);
    check("rst_rpend", 64'(bus_a.rpend), 64'd0);
    idle_a();
    #3 reset = 1'b0;
    #1;
    check("x5_cleared", 64'(bus_a.rd[31:0]), 64'd0);
    step();

    // same-cycle bypass, then the stored value
    bus_a.ra[9:5] = 5'd7;
    wr_a(0, 5'd7, 32'h12345678);
    #1;
    check("bypass_same_cycle", 64'(bus_a.rd[63:32]), 64'h12345678);
    step();
    idle_a();
    #1;
    check("bypass_stored", 64'(bus_a.rd[63:32]), 64'h12345678);
    step();

    // write-write collision: port 1 wins
    bus_a.ra[4:0] = 5'd3;
    wr_a(0, 5'd3, 32'h1);
    wr_a(1, 5'd3, 32'h2);
    #1;
    check("collide_comb", 64'(bus_a.rd[31:0]), 64'h2);
    step();
    idle_a();
    #1;
    check("collide_stored", 64'(bus_a.rd[31:0]), 64'h2);
    step();

    // zero register ignores writes and issue
    bus_a.ra[4:0] = 5'd0;
    wr_a(0, 5'd0, 32'hFFFFFFFF);
    iss_a(5'd0);
    #1;
    check("x0_rd_bypass", 64'(bus_a.rd[31:0]), 64'd0);
    check("x0_rpend", 64'(bus_a.rpend[0]), 64'd0);
    step();
    idle_a();
    #1;
    check("x0_pend", 64'(bus_a.pend_vec[0]), 64'd0);
    check("x0_rd_stored", 64'(bus_a.rd[31:0]), 64'd0);
    step();

    // scoreboard flow on x9
    bus_a.ra[4:0] = 5'd9;
    iss_a(5'd9);
    step();
    idle_a();
    #1;
    check("sb_pend9_set", 64'(bus_a.pend_vec[9]), 64'd1);
    check("sb_rpend_set", 64'(bus_a.rpend[0]), 64'd1);
    wr_a(0, 5'd9, 32'h55);
    #1;
    check("sb_rpend_bypassed", 64'(bus_a.rpend[0]), 64'd0);
    check("sb_rd_bypassed", 64'(bus_a.rd[31:0]), 64'h55);
    step();
    idle_a();
    #1;
    check("sb_pend9_clear", 64'(bus_a.pend_vec[9]), 64'd0);
    iss_a(5'd9);
    step();
    idle_a();
    wr_a(1, 5'd9, 32'h66);
    iss_a(5'd9);
    step();
    idle_a();
    #1;
    check("sb_set_wins", 64'(bus_a.pend_vec[9]), 64'd1);
    check("sb_rpend_reissue", 64'(bus_a.rpend[0]), 64'd1);
    check("sb_rd_reissue", 64'(bus_a.rd[31:0]), 64'h66);

    // random traffic on config A
    for (int c = 0; c < 3000; c++) begin
      step();
      bus_a.we = 2'($urandom_range(0, 3));
      for (int j = 0; j < 2; j++) begin
        bus_a.wa[j*5 +: 5]   = rand_addr();
        bus_a.wd[j*32 +: 32] = $urandom();
      end
      if ($urandom_range(0, 3) == 0) bus_a.wa[9:5] = bus_a.wa[4:0];
      bus_a.iss_v  = 1'($urandom_range(0, 1));
      bus_a.iss_rd = rand_addr();
      for (int i = 0; i < 2; i++)
        bus_a.ra[i*5 +: 5] = ($urandom_range(0, 2) == 0) ? bus_a.wa[i*5 +: 5] : rand_addr();
    end
    step();
    idle_a();

    for (int k = 0; k < 12000 && !done_b; k++) @(posedge clk);
    check("b_random_done", 64'(done_b), 64'd1);
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/xgriscv_regfile_mp.md
Name: xgriscv_regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the next-generation xgriscv core.
- Provides NREAD combinational read ports and NWRITE posedge write ports, with same-cycle write-to-read bypass.
- Includes a per-register pending-write scoreboard so the issue stage can detect RAW hazards.
- Sits between decode/issue (read ports, scoreboard set) and writeback (write ports, scoreboard clear).

Parameters:
- XLEN, 32, register data width in bits.
- NREG, 32, number of architectural registers; power of two, at least 2.
- AW, 5, register index width; equals log2(NREG).
- NREAD, 2, number of read ports (1..4).
- NWRITE, 2, number of write ports (1..2).
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and never pending; when 0 it is an ordinary register.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ra  in  NREAD*AW  read addresses; port i uses bits [i*AW +: AW].
- rd  out  NREAD*XLEN  read data; port i uses bits [i*XLEN +: XLEN].
- rpend  out  NREAD  port i: register ra[i] has an outstanding write (after bypass/clear this cycle).
- we  in  NWRITE  write enables.
- wa  in  NWRITE*AW  write addresses.
- wd  in  NWRITE*XLEN  write data.
- iss_v  in  1  issue valid; mark iss_rd pending.
- iss_rd  in  AW  destination register of the issuing instruction.
- pend_vec  out  NREG  full scoreboard, registered state.

Behaviour:
- Reset (async, any time including mid-write): all registers cleared to 0; pend_vec all 0. While reset is high, rd = 0 and rpend = 0 regardless of bypass. The first posedge after deassertion updates state normally.
- Write: at posedge, for each port j with we[j]=1, rf[wa[j]] <= wd[j]. If ZERO_REG=1 and wa[j]=0, the write is dropped.
- Write-write collision (same wa, both enabled): the higher-index port wins for both data and scoreboard clear.
- Read (combinational, zero latency): rd[i] priority is as follows.
  - ZERO_REG=1 and ra[i]=0 -> 0.
  - Otherwise, the highest-index port j with we[j] and wa[j]==ra[i] -> wd[j] (bypass).
  - Otherwise -> rf[ra[i]].
- Scoreboard next state, per register r:
  - Clear if any we[j] with wa[j]==r.
  - Set if iss_v and iss_rd==r.
  - Set and clear on the same r in the same cycle -> set wins (new producer issued).
  - ZERO_REG=1: pend[0] is forced to 0 always.
- rpend[i] = pend[ra[i]] AND NOT (any we[j] with wa[j]==ra[i]). A write in flight this cycle is satisfied by bypass.
- A write to a non-pending register is legal. Data is written and pend stays 0.
- Out-of-range addresses cannot occur (AW = log2 NREG).
- Timing: no combinational path from iss_v/iss_rd to rd or rpend. rd/rpend depend only on ra, we, wa, wd, and state.

Test Plan:
- Reset: assert reset mid-cycle after writing x5=0xDEADBEEF -> rd for x5 reads 0 immediately; pend_vec=0.
- Bypass: in one cycle, we[0]=1, wa=7, wd=0x12345678, ra[1]=7 -> rd[1]=0x12345678 in the same cycle; next cycle with we=0 -> rd[1] still 0x12345678.
- Collision: we=2'b11, wa[0]=wa[1]=3, wd0=0x1, wd1=0x2 -> rd shows 0x2 combinationally and after the edge.
- Zero register: write x0=0xFFFFFFFF with iss_v=1, iss_rd=0 -> rd for x0 = 0; pend_vec[0]=0; rpend=0.
- Scoreboard flow: iss x9 -> pend_vec[9]=1 and rpend=1 for ra=9.
  - Next cycle write x9 -> rpend=0 that cycle (bypass).
  - After the edge pend_vec[9]=0.
  - Same-cycle write x9 plus re-issue x9 -> pend_vec[9] stays 1.
- Parameter sweep: NREAD=4, NWRITE=1, XLEN=64, ZERO_REG=0 -> x0 is writable/pendable; random writes versus a reference model over 10k cycles with no mismatch.
